pulse_generator: RTL

//  Programmable square-wave source: the stimulus end of the frequency-counter link.

---
 rtl/pulse_generator.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pulse_generator.sv
// pulse_generator: programmable square-wave source.
// The output is high for HP clk cycles and then low for HP clk cycles.
// HP is loaded through a valid/ready slot with a one-entry pending register.
// A new HP takes effect only on a period boundary, so no runt pulse can appear.
// Optional feature macro: PULSE_BURST_EN. When it is defined, the block adds the
// i_burst and o_done ports and stops after a set number of pulses.
module pulse_generator #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned INIT_HP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             i_vld,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_rdy,
  output logic             pulse,
  output logic             o_rise,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_edges
`ifdef PULSE_BURST_EN
  ,
  input  logic [CNT_W-1:0] i_burst,
  output logic             o_done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] INIT_HP_W = CNT_W'(INIT_HP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0] active_hp_q, active_hp_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pulse_q, pulse_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] edges_q, edges_d;

  // Decode signals that are shared between the core and the burst logic.
  logic             accept;
  logic             hp_done;
  logic             start_ok;
  logic             boundary;
  logic [CNT_W-1:0] nhp;
  logic             start_from_idle;
  logic             rerise_from_low;
  logic             burst_end;
  logic             burst_last;
  logic             burst_lock;

  assign accept   = i_vld & ~pend_vld_q;
  assign hp_done  = (ph_cnt_q == active_hp_q);
  // A locked burst refuses to restart until en has been dropped.
  assign start_ok = en & ~burst_lock;

  // A boundary is the IDLE start decision or the last LOW cycle of a period.
  // An accept in the same cycle as a boundary sends i_cnt straight to active_hp.
  assign boundary = ((state_q == ST_IDLE) & start_ok) |
                    ((state_q == ST_LOW) & hp_done);
  assign nhp      = pend_vld_q ? pend_q : (accept ? i_cnt : active_hp_q);

  // Next state of the FSM and of the period counters. Defaults come first.
  always_comb begin
    state_d         = state_q;
    ph_cnt_d        = ph_cnt_q;
    active_hp_d     = active_hp_q;
    pend_d          = pend_q;
    pend_vld_d      = pend_vld_q;
    pulse_d         = pulse_q;
    rise_d          = 1'b0;
    edges_d         = edges_q;
    start_from_idle = 1'b0;
    rerise_from_low = 1'b0;
    burst_end       = 1'b0;

    // At a boundary, a pending or bypassed half-period replaces the active one.
    if (boundary) begin
      active_hp_d = nhp;
      pend_vld_d  = 1'b0;
    end else if (accept) begin
      pend_d     = i_cnt;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok && (nhp != '0)) begin
          state_d         = ST_HIGH;
          ph_cnt_d        = {{(CNT_W-1){1'b0}}, 1'b1};
          pulse_d         = 1'b1;
          rise_d          = 1'b1;
          edges_d         = edges_q + 1'b1;
          start_from_idle = 1'b1;
        end
      end
      ST_HIGH: begin
        if (hp_done) begin
          state_d  = ST_LOW;
          ph_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
          pulse_d  = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (hp_done) begin
          if (en && (nhp != '0) && !burst_last) begin
            state_d         = ST_HIGH;
            ph_cnt_d        = {{(CNT_W-1){1'b0}}, 1'b1};
            pulse_d         = 1'b1;
            rise_d          = 1'b1;
            edges_d         = edges_q + 1'b1;
            rerise_from_low = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            ph_cnt_d  = '0;
            pulse_d   = 1'b0;
            burst_end = burst_last;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ph_cnt_d = '0;
        pulse_d  = 1'b0;
      end
    endcase
  end

  // State and period registers. Reset is asynchronous, so pulse drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ph_cnt_q    <= '0;
      active_hp_q <= INIT_HP_W;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      pulse_q     <= 1'b0;
      rise_q      <= 1'b0;
      edges_q     <= '0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      active_hp_q <= active_hp_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      pulse_q     <= pulse_d;
      rise_q      <= rise_d;
      edges_q     <= edges_d;
    end
  end

`ifdef PULSE_BURST_EN
  logic [CNT_W-1:0] burst_tgt_q, burst_tgt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             lock_q, lock_d;
  logic             done_q, done_d;

  // A target of zero means continuous operation, so it never ends the burst.
  assign burst_last = (burst_tgt_q != '0) && (burst_cnt_q == burst_tgt_q);
  assign burst_lock = lock_q;
  assign o_done     = done_q;

  // Count the rises in a burst. After the burst ends, hold off until en falls.
  always_comb begin
    burst_tgt_d = burst_tgt_q;
    burst_cnt_d = burst_cnt_q;
    lock_d      = lock_q & en;
    done_d      = 1'b0;
    if (start_from_idle) begin
      burst_tgt_d = i_burst;
      burst_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (rerise_from_low) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
    if (burst_end) begin
      done_d = 1'b1;
      lock_d = 1'b1;
    end
  end

  // Burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_tgt_q <= '0;
      burst_cnt_q <= '0;
      lock_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      burst_tgt_q <= burst_tgt_d;
      burst_cnt_q <= burst_cnt_d;
      lock_q      <= lock_d;
      done_q      <= done_d;
    end
  end
`else
  // Without bursts the block runs continuously while en is high.
  assign burst_last = 1'b0;
  assign burst_lock = 1'b0;
`endif

  assign o_rdy   = ~pend_vld_q;
  assign pulse   = pulse_q;
  assign o_rise  = rise_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_edges = edges_q;

endmodule
